lattice_pattern_ctrl: RTL

Display scheduler for the 8x8 bicolour LED matrix. It generates the 64-bit red and green frame buffers that feed the row-scanning matrix driver. It arbitrates between pill-reminder alarms and user "show medicine" requests, and sequences the idle, show, blinking-alarm and missed-dose displays with millisecond timers.

---
 rtl/lattice_pkg.sv | 29 ++
 rtl/lattice_pattern_ctrl_ms_tick_gen.sv | 24 ++
 rtl/lattice_pattern_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lattice_pkg.sv
// Shared constants for the LED matrix display scheduler: glyph bitmaps,
// state encoding and the 2-bit glyph lookup.
package lattice_pkg;

    localparam logic [63:0] GLYPH_A    = 64'h0042427e42241800;
    localparam logic [63:0] GLYPH_B    = 64'h1C24241C24241C00;
    localparam logic [63:0] GLYPH_C    = 64'h001C220202221C00;
    localparam logic [63:0] GLYPH_PILL = 64'h003c3c3c24183C00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_ALARM  = 2'd2,
        ST_MISSED = 2'd3
    } state_t;

    // Slot/selector code to bitmap: 0 = A, 1 = B, 2 = C, 3 = pill icon.
    function automatic logic [63:0] glyph_sel(input logic [1:0] idx);
        logic [63:0] g;
        case (idx)
            2'd0:    g = GLYPH_A;
            2'd1:    g = GLYPH_B;
            2'd2:    g = GLYPH_C;
            default: g = GLYPH_PILL;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/lattice_pattern_ctrl_ms_tick_gen.sv
// Free-running millisecond strobe: one-cycle tick every TICK_DIV clocks.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Down-counter reloads on terminal count; never resynchronised by requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_cnt <= RELOAD;
        else if (r_cnt == '0)  r_cnt <= RELOAD;
        else                   r_cnt <= r_cnt - CW'(1);
    end

    assign tick = (r_cnt == '0);

endmodule

// File: rtl/lattice_pattern_ctrl.sv
// Display scheduler for the 8x8 bicolour matrix: arbitrates alarms and
// user glyph requests and produces the red/green frame buffers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | green pill icon, waiting for a request
// ST_SHOW   | green glyph for SHOW_MS ticks after the last show request
// ST_ALARM  | red glyph blinking at BLINK_MS, waiting for ack
// ST_MISSED | steady red pill after ALARM_MS ticks without ack
module lattice_pattern_ctrl
    import lattice_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int SHOW_MS  = 3000,
    parameter int BLINK_MS = 250,
    parameter int ALARM_MS = 60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alarm_req,
    input  logic [1:0]  alarm_slot,
    input  logic        show_req,
    input  logic [1:0]  show_sel,
    input  logic        ack,
    output logic [63:0] r_dis,
    output logic [63:0] g_dis,
    output logic [1:0]  state,
    output logic        missed
);

    localparam logic [16:0] SHOW_LIM  = 17'(SHOW_MS);
    localparam logic [16:0] ALARM_LIM = 17'(ALARM_MS);
    localparam logic [15:0] BLINK_LIM = 16'(BLINK_MS);

    logic        w_tick;
    state_t      r_state, w_state_nxt;
    logic [1:0]  r_sel, w_sel_nxt, r_slot, w_slot_nxt;
    logic        r_blink_on, w_blink_nxt;
    logic [16:0] r_ms_cnt, w_ms_nxt, w_ms_inc;
    logic [15:0] r_blink_cnt, w_blink_cnt_nxt, w_blink_inc;
    logic        w_entry;
    logic [63:0] w_r_nxt, w_g_nxt;
    logic        w_missed_nxt;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Next-state, counter and frame decode; alarm_req overrides everything.
    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_slot_nxt      = r_slot;
        w_blink_nxt     = r_blink_on;
        w_ms_nxt        = r_ms_cnt;
        w_blink_cnt_nxt = r_blink_cnt;
        w_entry         = 1'b0;
        w_ms_inc        = (r_ms_cnt == '1) ? r_ms_cnt : r_ms_cnt + 17'd1;
        w_blink_inc     = r_blink_cnt + 16'd1;

        if (w_tick) w_ms_nxt = w_ms_inc;

        if (r_state == ST_ALARM && w_tick) begin
            if (w_blink_inc == BLINK_LIM) begin
                w_blink_cnt_nxt = '0;
                w_blink_nxt     = ~r_blink_on;
            end else begin
                w_blink_cnt_nxt = w_blink_inc;
            end
        end

        if (alarm_req) begin
            w_state_nxt = ST_ALARM;
            w_slot_nxt  = alarm_slot;
            w_blink_nxt = 1'b1;
            w_entry     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (show_req) begin
                        w_state_nxt = ST_SHOW;
                        w_sel_nxt   = show_sel;
                        w_entry     = 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (show_req) begin
                        w_sel_nxt = show_sel;
                        w_entry   = 1'b1;
                    end else if (w_tick && w_ms_inc == SHOW_LIM) begin
                        w_state_nxt = ST_IDLE;
                        w_entry     = 1'b1;
                    end
                end
                ST_ALARM: begin
                    if (ack) begin
                        w_state_nxt = ST_IDLE;
                        w_entry     = 1'b1;
                    end else if (w_tick && w_ms_inc == ALARM_LIM) begin
                        w_state_nxt = ST_MISSED;
                        w_entry     = 1'b1;
                    end
                end
                default: begin
                    if (ack) begin
                        w_state_nxt = ST_IDLE;
                        w_entry     = 1'b1;
                    end
                end
            endcase
        end

        if (w_entry) begin
            w_ms_nxt        = '0;
            w_blink_cnt_nxt = '0;
        end

        w_r_nxt      = '0;
        w_g_nxt      = '0;
        case (w_state_nxt)
            ST_IDLE:  w_g_nxt = GLYPH_PILL;
            ST_SHOW:  w_g_nxt = glyph_sel(w_sel_nxt);
            ST_ALARM: w_r_nxt = w_blink_nxt ? glyph_sel(w_slot_nxt) : 64'd0;
            default:  w_r_nxt = GLYPH_PILL;
        endcase
        w_missed_nxt = (r_state == ST_ALARM) && (w_state_nxt == ST_MISSED);
    end

    // State, counters and frame registers all update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_slot      <= '0;
            r_blink_on  <= 1'b1;
            r_ms_cnt    <= '0;
            r_blink_cnt <= '0;
            r_dis       <= '0;
            g_dis       <= GLYPH_PILL;
            missed      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_slot      <= w_slot_nxt;
            r_blink_on  <= w_blink_nxt;
            r_ms_cnt    <= w_ms_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_dis       <= w_r_nxt;
            g_dis       <= w_g_nxt;
            missed      <= w_missed_nxt;
        end
    end

    assign state = r_state;

endmodule
